// File: rtl/rgb_frame_loader.sv
// Collects a sync-prefixed 192-byte RGB frame into a shadow buffer and commits it
// to eight 192-bit row registers in one cycle, so the LED driver never sees a partial frame.
module rgb_frame_loader #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
   parameter int unsigned TIMEOUT_CYCLES = 1_200_000,
   parameter int unsigned TMR_W          = 21
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [0:191] rgb_data_01,
   output logic [0:191] rgb_data_02,
   output logic [0:191] rgb_data_03,
   output logic [0:191] rgb_data_04,
   output logic [0:191] rgb_data_05,
   output logic [0:191] rgb_data_06,
   output logic [0:191] rgb_data_07,
   output logic [0:191] rgb_data_08,
   output logic         rgb_ext_activ,
   output logic         frame_done,
   output logic         frame_error,
   output logic         busy
);

   localparam logic [7:0]       LAST_BYTE = 8'd191;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       byte_cnt_q, byte_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             store_en, commit_en, error_en;
   logic [0:1535]    shadow;
   logic [10:0]      wr_base;

   // Byte b lands at flat bit b*8, which is row b/24, offset (b mod 24)*8, MSB first.
   assign wr_base = {byte_cnt_q, 3'b000};

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      timer_d    = timer_q;
      store_en   = 1'b0;
      commit_en  = 1'b0;
      error_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d    = RECV;
               byte_cnt_d = 8'd0;
               timer_d    = '0;
            end
         end
         RECV: begin
            if (rx_valid) begin
               store_en = 1'b1;
               timer_d  = '0;
               if (byte_cnt_q == LAST_BYTE) state_d = COMMIT;
               else                         byte_cnt_d = byte_cnt_q + 8'd1;
            end else if (timer_q == TMR_LAST) begin
               error_en = 1'b1;
               timer_d  = '0;
               state_d  = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         COMMIT: begin
            commit_en = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         byte_cnt_q <= 8'd0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         timer_q    <= timer_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) shadow <= '0;
      else if (store_en) shadow[wr_base +: 8] <= rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_data_01   <= '0;
         rgb_data_02   <= '0;
         rgb_data_03   <= '0;
         rgb_data_04   <= '0;
         rgb_data_05   <= '0;
         rgb_data_06   <= '0;
         rgb_data_07   <= '0;
         rgb_data_08   <= '0;
         rgb_ext_activ <= 1'b0;
         frame_done    <= 1'b0;
         frame_error   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (commit_en) begin
            rgb_data_01   <= shadow[0    +: 192];
            rgb_data_02   <= shadow[192  +: 192];
            rgb_data_03   <= shadow[384  +: 192];
            rgb_data_04   <= shadow[576  +: 192];
            rgb_data_05   <= shadow[768  +: 192];
            rgb_data_06   <= shadow[960  +: 192];
            rgb_data_07   <= shadow[1152 +: 192];
            rgb_data_08   <= shadow[1344 +: 192];
            rgb_ext_activ <= 1'b1;
         end
         frame_done  <= commit_en;
         frame_error <= error_en;
         busy        <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Bench for rgb_frame_loader: frame-level reference model feeds an expected-event queue,
// a negedge monitor checks output levels every cycle and pops on frame_done/frame_error.
module tb_rgb_frame_loader;

   localparam int TO = 100;
   localparam int W  = 1570;   // {stamp[31:0], is_error, ext_activ, image[1535:0]}

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   rx_data = 8'd0;
   logic         rx_valid = 1'b0;
   logic [0:191] r1, r2, r3, r4, r5, r6, r7, r8;
   logic         act, done, err, busy;

   always #5 clk = ~clk;

   rgb_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rgb_data_01(r1), .rgb_data_02(r2), .rgb_data_03(r3), .rgb_data_04(r4),
      .rgb_data_05(r5), .rgb_data_06(r6), .rgb_data_07(r7), .rgb_data_08(r8),
      .rgb_ext_activ(act), .frame_done(done), .frame_error(err), .busy(busy)
   );

   int checks = 0, failures = 0;
   int cyc = 0, done_cnt = 0, err_cnt = 0;
   bit run = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] exp_q[$];
   logic [7:0]   tx_q[$];

   // reference model state (frame level)
   bit            m_in_frame, m_commit_next, m_busy, m_act;
   logic [7:0]    m_payload[$];
   int            m_silent;
   logic [0:1535] m_shown;

   task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp_img(input string name, input logic [0:1535] got, input logic [0:1535] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         for (int r = 0; r < 8; r++) begin
            if (got[r*192 +: 192] !== exp[r*192 +: 192]) begin
               $display("FAIL %s row %0d: got %h expected %h", name, r + 1,
                        got[r*192 +: 192], exp[r*192 +: 192]);
               break;
            end
         end
      end
   endtask

   // Builds the eight row words from the received bytes: row b/24, offset (b mod 24)*8.
   function automatic logic [0:1535] frame_image();
      logic [0:1535] f;
      f = '0;
      for (int b = 0; b < 192; b++) begin
         int row, off;
         row = b / 24;
         off = (b % 24) * 8;
         f[row*192 + off +: 8] = m_payload[b];
      end
      return f;
   endfunction

   task automatic model_reset();
      m_in_frame = 0; m_commit_next = 0; m_busy = 0; m_act = 0;
      m_silent = 0; m_shown = '0;
      m_payload.delete();
      exp_q.delete();
   endtask

   // Advances the model by one clock edge with the given input.
   task automatic model_edge(input bit v, input logic [7:0] d);
      int e;
      e = cyc + 1;
      if (m_commit_next) begin
         m_commit_next = 0;
         m_shown = frame_image();
         m_act = 1;
      end else if (!m_in_frame) begin
         if (v && d == 8'hAA) begin
            m_in_frame = 1;
            m_payload.delete();
            m_silent = 0;
         end
      end else if (v) begin
         m_payload.push_back(d);
         m_silent = 0;
         if (m_payload.size() == 192) begin
            m_in_frame = 0;
            m_commit_next = 1;
            exp_q.push_back({32'(e + 1), 1'b0, 1'b1, frame_image()});
         end
      end else begin
         m_silent++;
         if (m_silent == TO) begin
            m_in_frame = 0;
            exp_q.push_back({32'(e), 1'b1, m_act, m_shown});
         end
      end
      m_busy = m_in_frame || m_commit_next;
   endtask

   task automatic put(input bit v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
   endtask

   function automatic logic [7:0] non_sync();
      logic [7:0] v;
      do v = 8'($urandom_range(0, 255)); while (v == 8'hAA);
      return v;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 8'($urandom_range(0, 255)));
   endtask

   task automatic send_frame(input int max_gap);
      put(1'b1, 8'hAA);
      foreach (tx_q[i]) begin
         put(1'b1, tx_q[i]);
         if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic random_payload();
      tx_q.delete();
      for (int i = 0; i < 192; i++) tx_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // monitor: level checks every cycle, event checks against the expected queue
   logic [0:1535] dut_img;
   logic [W-1:0]  ev;
   always @(negedge clk) begin
      if (run && !rst) begin
         dut_img = {r1, r2, r3, r4, r5, r6, r7, r8};
         cmp_img("rows", dut_img, m_shown);
         chk("busy", busy, m_busy);
         chk("ext_activ", act, m_act);
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (done || err) begin
            checks++;
            if (done && err) begin
               failures++;
               $display("FAIL pulses: frame_done and frame_error both high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL pulse_unexpected: done=%0b error=%0b at cycle %0d, none expected", done, err, cyc);
            end else begin
               ev = exp_q.pop_front();
               chk("pulse_cycle", cyc, ev[1569:1538]);
               chk("pulse_kind_error", err, ev[1537]);
               chk("pulse_ext_activ", act, ev[1536]);
               cmp_img("pulse_rows", dut_img, ev[1535:0]);
            end
         end else if (exp_q.size() > 0 && int'(exp_q[0][1569:1538]) <= cyc) begin
            checks++;
            failures++;
            ev = exp_q.pop_front();
            $display("FAIL pulse_missing: expected %s at cycle %0d, still absent at cycle %0d",
                     ev[1537] ? "frame_error" : "frame_done", ev[1569:1538], cyc);
         end
      end
   end

   int d0, e0;

   initial begin
      // reset
      repeat (3) @(negedge clk);
      cmp_img("reset_rows", {r1, r2, r3, r4, r5, r6, r7, r8}, '0);
      chk("reset_activ", act, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_pulses", {done, err}, 2'b00);
      #2 rst = 1'b0;
      model_reset();
      run = 1;
      @(negedge clk);
      idle(10);

      // full frame, value = index
      tx_q.delete();
      for (int i = 0; i < 192; i++) tx_q.push_back(8'(i));
      send_frame(0);
      idle(4);
      chk("full_r1_b0", r1[0:7], 8'h00);
      chk("full_r1_b1", r1[8:15], 8'h01);
      chk("full_r2_b0", r2[0:7], 8'h18);
      chk("full_r8_b23", r8[184:191], 8'hBF);
      chk("full_done_cnt", done_cnt, 1);
      chk("full_activ", act, 1'b1);

      // idle filtering, then sync value inside payload
      put(1'b1, 8'h00); put(1'b0, 8'h00); put(1'b1, 8'h55); put(1'b1, 8'hFF);
      idle(2);
      chk("filter_busy", busy, 1'b0);
      random_payload();
      tx_q[5] = 8'hAA;
      send_frame(2);
      idle(4);
      chk("payload_sync_byte", r1[40:47], 8'hAA);
      chk("filter_done_cnt", done_cnt, 2);

      // timeout after 10 bytes; outputs and activ keep their values
      put(1'b1, 8'hAA);
      for (int i = 0; i < 10; i++) put(1'b1, 8'($urandom_range(0, 255)));
      idle(TO + 5);
      chk("timeout_err_cnt", err_cnt, 1);
      chk("timeout_activ", act, 1'b1);
      tx_q.delete();
      for (int i = 0; i < 192; i++) tx_q.push_back(8'h3C);
      send_frame(1);
      idle(4);
      chk("after_timeout_r5", r5[96:103], 8'h3C);
      chk("after_timeout_done_cnt", done_cnt, 3);

      // byte on exactly the last silent cycle wins over the timeout
      random_payload();
      tx_q[3] = 8'h5A;
      put(1'b1, 8'hAA);
      for (int i = 0; i < 3; i++) put(1'b1, tx_q[i]);
      idle(TO - 1);
      put(1'b1, tx_q[3]);
      for (int i = 4; i < 192; i++) put(1'b1, tx_q[i]);
      idle(4);
      chk("boundary_err_cnt", err_cnt, 1);
      chk("boundary_byte", r1[24:31], 8'h5A);

      // sync byte during COMMIT is dropped
      random_payload();
      send_frame(0);
      put(1'b1, 8'hAA);
      put(1'b0, 8'h00);
      chk("commit_drop_busy", busy, 1'b0);

      // random frames with idle-time junk
      for (int f = 0; f < 3; f++) begin
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) put(1'b1, non_sync());
         idle($urandom_range(0, 3));
         random_payload();
         send_frame(3);
         idle($urandom_range(2, 5));
      end
      chk("random_done_cnt", done_cnt, 8);

      // asynchronous reset mid-frame
      put(1'b1, 8'hAA);
      for (int i = 0; i < 100; i++) put(1'b1, 8'($urandom_range(0, 255)));
      #2 rst = 1'b1;
      #1;
      cmp_img("midreset_rows", {r1, r2, r3, r4, r5, r6, r7, r8}, '0);
      chk("midreset_activ", act, 1'b0);
      chk("midreset_busy", busy, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      d0 = done_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 191; i++) put(1'b1, 8'h11);
      idle(4);
      chk("midreset_no_done", done_cnt, d0);
      chk("midreset_idle", busy, 1'b0);
      chk("midreset_no_error", err_cnt, e0);

      idle(5);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
